fixpoint_stepper: RTL and testbench

FIXPOINT_STEPPER -- requirements
Module: fixpoint_stepper

---
 rtl/fixpoint_stepper.sv | 139 +++++++++++++
 tb/tb_fixpoint_stepper.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixpoint_stepper.sv
// fixpoint_stepper: steps a lock-masked saturating counter from a captured
// initial state until the state stops changing or a step bound is reached.
module fixpoint_stepper #(
    parameter int W  = 10,
    parameter int SW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  init_state,
    input  logic [W-1:0]  lock_mask,
    input  logic          inc,
    input  logic [SW-1:0] max_steps,
    input  logic [W-1:0]  bad_state,
    output logic          busy,
    output logic          done,
    output logic          fixpoint,
    output logic          bug,
    output logic [SW-1:0] steps,
    output logic [W-1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t          fsm_q;
    fsm_t          fsm_nxt;

    logic [W-1:0]  s_q;
    logic [W-1:0]  lock_q;
    logic [W-1:0]  bad_q;
    logic          inc_q;
    logic [SW-1:0] max_q;
    logic [SW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          fix_q;
    logic          bug_q;

    logic [W:0]    c;
    logic [W-1:0]  nxt;
    logic          is_fix;
    logic          at_bound;

    // Transition: ripple carry through unlocked bits, locked bits pass the
    // carry untouched; a carry out of the top means saturate in place.
    always_comb begin
        c    = '0;
        nxt  = s_q;
        c[0] = inc_q;
        for (int unsigned i = 0; i < W; i++) begin
            c[i+1] = c[i] & (s_q[i] | lock_q[i]);
            nxt[i] = s_q[i] ^ (c[i] & ~lock_q[i]);
        end
        if (c[W]) begin
            nxt = s_q;
        end
    end

    assign is_fix   = (nxt == s_q);
    assign at_bound = (cnt_q == max_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_nxt;
        end
    end

    // FSM next-state decode; fixpoint and bound both end the run.
    always_comb begin
        fsm_nxt = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_nxt = RUN;
            RUN:     if (is_fix || at_bound) fsm_nxt = DONE;
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Datapath: capture at start, step during RUN, latch result on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            lock_q <= '0;
            bad_q  <= '0;
            inc_q  <= 1'b0;
            max_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fix_q  <= 1'b0;
            bug_q  <= 1'b0;
        end else begin
            busy_q <= (fsm_nxt == RUN);
            done_q <= (fsm_q == RUN) && (fsm_nxt == DONE);
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        s_q    <= init_state;
                        lock_q <= lock_mask;
                        bad_q  <= bad_state;
                        inc_q  <= inc;
                        max_q  <= max_steps;
                        cnt_q  <= '0;
                        fix_q  <= 1'b0;
                        bug_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (is_fix) begin
                        fix_q <= 1'b1;
                        bug_q <= (s_q == bad_q);
                    end else if (at_bound) begin
                        fix_q <= 1'b0;
                        bug_q <= (s_q == bad_q);
                    end else begin
                        s_q   <= nxt;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fixpoint  = fix_q;
    assign bug       = bug_q;
    assign steps     = cnt_q;
    assign state_out = s_q;

endmodule

// File: tb/tb_fixpoint_stepper.sv
// Self-checking bench for fixpoint_stepper: expected results come from an
// independent compress/increment/scatter model and flow through a queue.
module tb_fixpoint_stepper;

    localparam int W  = 10;
    localparam int SW = 11;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  init_state;
    logic [W-1:0]  lock_mask;
    logic          inc;
    logic [SW-1:0] max_steps;
    logic [W-1:0]  bad_state;
    logic          busy;
    logic          done;
    logic          fixpoint;
    logic          bug;
    logic [SW-1:0] steps;
    logic [W-1:0]  state_out;

    typedef struct {
        logic          fix;
        logic          bug;
        logic [SW-1:0] steps;
        logic [W-1:0]  st;
        int            cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    fixpoint_stepper #(.W(W), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_state (init_state),
        .lock_mask  (lock_mask),
        .inc        (inc),
        .max_steps  (max_steps),
        .bad_state  (bad_state),
        .busy       (busy),
        .done       (done),
        .fixpoint   (fixpoint),
        .bug        (bug),
        .steps      (steps),
        .state_out  (state_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Gather unlocked bits, add one unless they are all ones, scatter back.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] s,
                                                input logic [W-1:0] lock,
                                                input logic i_inc);
        logic [W-1:0] u;
        logic [W-1:0] r;
        int k;
        u = '0;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (!lock[i]) begin
                u[k] = s[i];
                k++;
            end
        end
        if (!i_inc) return s;
        if (int'(u) == ((1 << k) - 1)) return s;
        u = u + 1'b1;
        r = s;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (!lock[i]) begin
                r[i] = u[k];
                k++;
            end
        end
        return r;
    endfunction

    function automatic exp_t model_run(input logic [W-1:0] init,
                                       input logic [W-1:0] lock,
                                       input logic i_inc,
                                       input logic [SW-1:0] mx,
                                       input logic [W-1:0] bad);
        exp_t e;
        logic [W-1:0] s;
        logic [W-1:0] n;
        int cnt;
        s = init;
        cnt = 0;
        e.cycles = 0;
        e.fix = 1'b0;
        for (int guard = 0; guard < 5000; guard++) begin
            e.cycles++;
            n = model_next(s, lock, i_inc);
            if (n == s) begin
                e.fix = 1'b1;
                break;
            end else if (cnt == int'(mx)) begin
                e.fix = 1'b0;
                break;
            end else begin
                s = n;
                cnt++;
            end
        end
        e.st    = s;
        e.steps = SW'(cnt);
        e.bug   = (s == bad);
        return e;
    endfunction

    // Drive a start with the given inputs for one accepting edge and queue the expectation.
    task automatic run_start(input logic [W-1:0] i_init, input logic [W-1:0] i_lock,
                             input logic i_inc, input logic [SW-1:0] i_max,
                             input logic [W-1:0] i_bad);
        @(posedge clk);
        #1;
        init_state = i_init;
        lock_mask  = i_lock;
        inc        = i_inc;
        max_steps  = i_max;
        bad_state  = i_bad;
        start      = 1'b1;
        sb.push_back(model_run(i_init, i_lock, i_inc, i_max, i_bad));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, pop the oldest expectation and compare; then check the
    // done pulse width and that results hold. With poke set, a start is raised
    // while in DONE (it must be ignored there).
    task automatic scoreboard_pop_compare(input int pre_cycles, input bit poke);
        exp_t e;
        int cyc;
        bit seen;
        cyc = pre_cycles;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) cyc++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b required 1 within budget", done);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: size=0 required >0");
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (fixpoint !== e.fix) begin
            n_fail++;
            $display("FAIL fixpoint: got %b required %b", fixpoint, e.fix);
        end
        n_checks++;
        if (bug !== e.bug) begin
            n_fail++;
            $display("FAIL bug: got %b required %b", bug, e.bug);
        end
        n_checks++;
        if (steps !== e.steps) begin
            n_fail++;
            $display("FAIL steps: got %0d required %0d", steps, e.steps);
        end
        n_checks++;
        if (state_out !== e.st) begin
            n_fail++;
            $display("FAIL state_out: got %h required %h", state_out, e.st);
        end
        n_checks++;
        if (cyc != e.cycles) begin
            n_fail++;
            $display("FAIL run_cycles: got %0d required %0d", cyc, e.cycles);
        end
        if (poke) begin
            init_state = 10'h2AA;
            bad_state  = 10'h2AA;
            start      = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
        end
        n_checks++;
        if (fixpoint !== e.fix || bug !== e.bug || steps !== e.steps || state_out !== e.st) begin
            n_fail++;
            $display("FAIL hold: fix=%b bug=%b steps=%0d st=%h required %b %b %0d %h",
                     fixpoint, bug, steps, state_out, e.fix, e.bug, e.steps, e.st);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        init_state = '0;
        lock_mask = '0;
        inc = 1'b0;
        max_steps = '0;
        bad_state = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, fixpoint, bug, steps, state_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {busy, done, fixpoint, bug, steps, state_out});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count_up;
        run_start(10'h3F0, 10'h000, 1'b1, 11'd2047, 10'h3FF);
        n_checks++;
        if (sb[sb.size()-1].cycles != 16 || sb[sb.size()-1].st != 10'h3FF) begin
            n_fail++;
            $display("FAIL model_count_up: cycles=%0d st=%h required 16 3ff",
                     sb[sb.size()-1].cycles, sb[sb.size()-1].st);
        end
        scoreboard_pop_compare(0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_start(10'h155, 10'h000, 1'b0, 11'd5, 10'h000);
        scoreboard_pop_compare(0, 1'b1);
        // start was high across the DONE edge (ignored); the IDLE edge accepts it
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model_run(10'h2AA, 10'h000, 1'b0, 11'd5, 10'h2AA));
        scoreboard_pop_compare(0, 1'b0);
    endtask

    task automatic test_bound;
        run_start(10'h000, 10'h000, 1'b1, 11'd100, 10'h000);
        scoreboard_pop_compare(0, 1'b0);
    endtask

    task automatic test_max_zero_rerun;
        run_start(10'h000, 10'h3FE, 1'b1, 11'd0, 10'h000);
        scoreboard_pop_compare(0, 1'b0);
        run_start(10'h000, 10'h3FE, 1'b1, 11'd1, 10'h000);
        scoreboard_pop_compare(0, 1'b0);
    endtask

    task automatic test_start_ignored;
        int pre;
        pre = 0;
        run_start(10'h3F0, 10'h000, 1'b1, 11'd2047, 10'h3FF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy === 1'b1) pre++;
            if (k == 2) begin
                init_state = 10'h000;
                lock_mask  = 10'h0F0;
                inc        = 1'b0;
                max_steps  = 11'd1;
                bad_state  = 10'h000;
                start      = 1'b1;
            end
            if (k == 3) start = 1'b0;
        end
        scoreboard_pop_compare(pre, 1'b0);
    endtask

    task automatic test_reset_midrun;
        run_start(10'h000, 10'h000, 1'b1, 11'd100, 10'h000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, fixpoint, bug, steps, state_out} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b required all zero",
                     {busy, done, fixpoint, bug, steps, state_out});
        end
        void'(sb.pop_back());
        init_state = 10'h3F8;
        lock_mask  = 10'h000;
        inc        = 1'b1;
        max_steps  = 11'd20;
        bad_state  = 10'h001;
        start      = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model_run(10'h3F8, 10'h000, 1'b1, 11'd20, 10'h001));
        scoreboard_pop_compare(0, 1'b0);
    endtask

    task automatic test_random;
        exp_t e;
        logic [W-1:0] ri;
        logic [W-1:0] rl;
        logic [W-1:0] rb;
        logic ric;
        logic [SW-1:0] rm;
        for (int n = 0; n < 8; n++) begin
            ri  = W'($urandom);
            rl  = W'($urandom) & W'($urandom);
            ric = ($urandom_range(0, 3) != 0);
            rm  = SW'($urandom_range(0, 40));
            e   = model_run(ri, rl, ric, rm, '0);
            rb  = ($urandom_range(0, 1) != 0) ? e.st : W'($urandom);
            run_start(ri, rl, ric, rm, rb);
            scoreboard_pop_compare(0, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_count_up();
        test_back_to_back();
        test_bound();
        test_max_zero_rerun();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
